// File: rtl/sock_frame_rx.sv
// Socket byte-stream frame receiver: hunts SOF, buffers payload words until the
// XOR checksum is verified, then replays good frames as a 32-bit word stream.
module sock_frame_rx #(
  parameter int         MAX_WORDS = 16,
  parameter int         TIMEOUT   = 255,
  parameter logic [7:0] SOF       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [7:0]  out_cmd,
  output logic        out_last,
  input  logic        out_ready,
  output logic        frame_ok,
  output logic        frame_err,
  output logic [1:0]  err_code
);

  localparam int PW = $clog2(MAX_WORDS + 1);
  localparam int AW = (MAX_WORDS > 1) ? $clog2(MAX_WORDS) : 1;
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_HUNT, S_CMD, S_LEN, S_PAY, S_CSUM, S_DRAIN} state_t;

  state_t        r_state, w_nstate;
  logic          r_in_ready, r_out_valid, r_out_last, r_ok, r_err;
  logic [31:0]   r_out_data;
  logic [7:0]    r_out_cmd, r_cmd, r_xor;
  logic [1:0]    r_code, w_code, r_bcnt;
  logic [23:0]   r_asm;
  logic [PW-1:0] r_len, r_wr, r_rd;
  logic [TW-1:0] r_tmo;
  logic [31:0]   r_buf [MAX_WORDS];
  logic          w_ok, w_err, w_acc, w_infr, w_tmo_hit, w_wr_en, w_hs;

  assign w_acc     = in_valid && r_in_ready;
  assign w_infr    = (r_state == S_CMD) || (r_state == S_LEN) ||
                     (r_state == S_PAY) || (r_state == S_CSUM);
  // An accepted byte in the threshold cycle wins over the timeout.
  assign w_tmo_hit = w_infr && !w_acc && (r_tmo == TW'(TIMEOUT - 1));
  assign w_wr_en   = (r_state == S_PAY) && w_acc && (r_bcnt == 2'd3);
  assign w_hs      = r_out_valid && out_ready;

  always_comb begin
    w_nstate = r_state;
    w_ok     = 1'b0;
    w_err    = 1'b0;
    w_code   = 2'd0;
    case (r_state)
      S_HUNT: if (w_acc && in_data == SOF) w_nstate = S_CMD;
      S_CMD:  if (w_acc) w_nstate = S_LEN;
      S_LEN:
        if (w_acc) begin
          if (in_data > 8'(MAX_WORDS)) begin
            w_err    = 1'b1;
            w_code   = 2'd2;
            w_nstate = S_HUNT;
          end else if (in_data == 8'd0) begin
            w_nstate = S_CSUM;
          end else begin
            w_nstate = S_PAY;
          end
        end
      S_PAY: if (w_wr_en && r_wr == r_len - PW'(1)) w_nstate = S_CSUM;
      S_CSUM:
        if (w_acc) begin
          if (in_data == r_xor) begin
            w_ok     = 1'b1;
            w_nstate = (r_len == '0) ? S_HUNT : S_DRAIN;
          end else begin
            w_err    = 1'b1;
            w_code   = 2'd1;
            w_nstate = S_HUNT;
          end
        end
      S_DRAIN: if (w_hs && r_out_last) w_nstate = S_HUNT;
      default: w_nstate = S_HUNT;
    endcase
    if (w_tmo_hit) begin
      w_err    = 1'b1;
      w_code   = 2'd3;
      w_nstate = S_HUNT;
    end
  end

  always_ff @(posedge clk)
    if (w_wr_en) r_buf[r_wr[AW-1:0]] <= {in_data, r_asm};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_HUNT;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
      r_out_data  <= '0;
      r_out_cmd   <= '0;
      r_ok        <= 1'b0;
      r_err       <= 1'b0;
      r_code      <= '0;
      r_cmd       <= '0;
      r_xor       <= '0;
      r_bcnt      <= '0;
      r_asm       <= '0;
      r_len       <= '0;
      r_wr        <= '0;
      r_rd        <= '0;
      r_tmo       <= '0;
    end else begin
      r_state    <= w_nstate;
      r_ok       <= w_ok;
      r_err      <= w_err;
      r_code     <= w_code;
      r_in_ready <= (w_nstate != S_DRAIN);
      r_tmo      <= (w_infr && !w_acc && !w_tmo_hit) ? r_tmo + TW'(1) : '0;
      case (r_state)
        S_HUNT:
          if (w_acc && in_data == SOF) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_bcnt <= '0;
          end
        S_CMD:
          if (w_acc) begin
            r_cmd <= in_data;
            r_xor <= in_data;
          end
        S_LEN:
          if (w_acc) begin
            r_xor <= r_xor ^ in_data;
            r_len <= in_data[PW-1:0];
          end
        S_PAY:
          if (w_acc) begin
            r_xor  <= r_xor ^ in_data;
            r_asm  <= {in_data, r_asm[23:8]};
            r_bcnt <= r_bcnt + 2'd1;
            if (r_bcnt == 2'd3) r_wr <= r_wr + PW'(1);
          end
        S_CSUM:
          if (w_acc && in_data == r_xor && r_len != '0) begin
            r_out_valid <= 1'b1;
            r_out_data  <= r_buf[0];
            r_out_cmd   <= r_cmd;
            r_out_last  <= (r_len == PW'(1));
            r_rd        <= PW'(1);
          end
        S_DRAIN:
          if (w_hs) begin
            if (r_out_last) begin
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
            end else begin
              r_out_data <= r_buf[r_rd[AW-1:0]];
              r_out_last <= (r_rd == r_len - PW'(1));
              r_rd       <= r_rd + PW'(1);
            end
          end
        default: ;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_cmd   = r_out_cmd;
  assign out_last  = r_out_last;
  assign frame_ok  = r_ok;
  assign frame_err = r_err;
  assign err_code  = r_code;

endmodule

// File: tb/tb_sock_frame_rx.sv
// Directed bench for sock_frame_rx: spec frames, error paths, timeout, backpressure, reset.
module tb_sock_frame_rx;
  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready, out_valid, out_last, frame_ok, frame_err;
  logic [31:0] out_data;
  logic [7:0]  out_cmd;
  logic [1:0]  err_code;

  int n_vec = 0, n_bad = 0, n_ok = 0, n_err = 0;
  logic [32:0] mon_q[$];

  sock_frame_rx dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_cmd(out_cmd), .out_last(out_last),
    .out_ready(out_ready), .frame_ok(frame_ok), .frame_err(frame_err), .err_code(err_code)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (out_valid && out_ready) mon_q.push_back({out_last, out_data});
    if (frame_ok)  n_ok++;
    if (frame_err) n_err++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic sb(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic good_frame(input logic [7:0] cmd, input int nw, input logic [7:0] seed,
                            input string tag);
    logic [7:0]  cs;
    logic [32:0] e;
    int k;
    mon_q.delete();
    out_ready = 1'b1;
    cs = cmd ^ 8'(nw);
    sb(8'hA5); sb(cmd); sb(8'(nw));
    for (int j = 0; j < 4 * nw; j++) begin
      sb(8'(seed + j));
      cs ^= 8'(seed + j);
    end
    sb(cs);
    idle();
    chk({tag, "_ok"}, frame_ok, 1);
    k = 0;
    while (out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_drained"}, out_valid, 0);
    chk({tag, "_nwords"}, mon_q.size(), nw);
    for (int w = 0; w < nw && w < mon_q.size(); w++) begin
      e = {(w == nw - 1), 8'(seed + 4*w + 3), 8'(seed + 4*w + 2), 8'(seed + 4*w + 1), 8'(seed + 4*w)};
      chk({tag, "_word"}, mon_q[w], e);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [7:0]  fa [11];
    logic [40:0] prev;
    logic        tog, stall;
    int          k, e0, o0;
    fa = '{8'hA5, 8'h10, 8'h02, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};

    // reset state
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_cmd", out_cmd, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_pulses", {frame_ok, frame_err, err_code}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);

    // spec good frame, cycle-exact
    mon_q.delete();
    for (int i = 0; i < 11; i++) sb(fa[i]);
    sb(8'h1A);
    idle();
    chk("g_ok", frame_ok, 1);
    chk("g_v0", out_valid, 1);
    chk("g_d0", out_data, 32'h04030201);
    chk("g_cmd0", out_cmd, 8'h10);
    chk("g_last0", out_last, 0);
    chk("g_inrdy0", in_ready, 0);
    @(negedge clk);
    chk("g_okpulse", frame_ok, 0);
    chk("g_d1", out_data, 32'h08070605);
    chk("g_cmd1", out_cmd, 8'h10);
    chk("g_last1", out_last, 1);
    @(negedge clk);
    chk("g_done", out_valid, 0);
    chk("g_inrdy_back", in_ready, 1);

    // checksum error
    mon_q.delete();
    for (int i = 0; i < 11; i++) sb(fa[i]);
    sb(8'h1B);
    idle();
    chk("cs_err", frame_err, 1);
    chk("cs_code", err_code, 1);
    chk("cs_ok", frame_ok, 0);
    chk("cs_nov", out_valid, 0);
    repeat (3) @(negedge clk);
    chk("cs_errpulse", frame_err, 0);
    chk("cs_nowords", mon_q.size(), 0);
    good_frame(8'h10, 2, 8'h01, "cs_next");

    // length error, trailing bytes ignored
    o0 = n_ok; e0 = n_err;
    sb(8'hA5); sb(8'h22); sb(8'h11);
    idle();
    chk("len_err", frame_err, 1);
    chk("len_code", err_code, 2);
    sb(8'h01); sb(8'h02);
    chk("len_pulse", frame_err, 0);
    sb(8'h03); sb(8'h04); sb(8'h10); sb(8'h00);
    repeat (3) idle();
    chk("len_counts", {32'(n_ok - o0), 32'(n_err - e0)}, {32'd0, 32'd1});
    good_frame(8'h21, 1, 8'h40, "len_next");

    // timeout
    sb(8'hA5); sb(8'h30); sb(8'h01);
    repeat (255) idle();
    chk("tmo_early", frame_err, 0);
    idle();
    chk("tmo_err", frame_err, 1);
    chk("tmo_code", err_code, 3);
    good_frame(8'h31, 3, 8'h80, "tmo_next");

    // byte at the timeout threshold wins
    mon_q.delete();
    e0 = n_err;
    sb(8'hA5); sb(8'h30); sb(8'h01);
    repeat (254) idle();
    sb(8'h11); sb(8'h22);
    chk("thr_noerr", frame_err, 0);
    sb(8'h33); sb(8'h44); sb(8'h75);
    idle();
    chk("thr_ok", frame_ok, 1);
    chk("thr_word", out_data, 32'h44332211);
    chk("thr_last", out_last, 1);
    repeat (2) idle();
    chk("thr_errcnt", n_err - e0, 0);

    // backpressure, 16 words
    mon_q.delete();
    begin
      logic [7:0] cs;
      cs = 8'h55 ^ 8'd16;
      sb(8'hA5); sb(8'h55); sb(8'd16);
      for (int j = 0; j < 64; j++) begin
        sb(8'(8'h10 + j));
        cs ^= 8'(8'h10 + j);
      end
      sb(cs);
    end
    idle();
    chk("bp_ok", frame_ok, 1);
    k = 0; tog = 1'b0; stall = 1'b0; prev = '0;
    while (out_valid && k < 100) begin
      if (stall) chk("bp_hold", {out_last, out_cmd, out_data}, prev);
      chk("bp_inrdy", in_ready, 0);
      prev  = {out_last, out_cmd, out_data};
      out_ready = tog;
      stall = !tog;
      tog   = !tog;
      @(negedge clk);
      k++;
    end
    out_ready = 1'b1;
    chk("bp_drained", out_valid, 0);
    chk("bp_inrdy_back", in_ready, 1);
    chk("bp_nwords", mon_q.size(), 16);
    for (int w = 0; w < 16 && w < mon_q.size(); w++)
      chk("bp_word", mon_q[w], {(w == 15), 8'(16 + 4*w + 3), 8'(16 + 4*w + 2),
                                8'(16 + 4*w + 1), 8'(16 + 4*w)});

    // zero-length frame
    mon_q.delete();
    sb(8'hA5); sb(8'h07); sb(8'h00); sb(8'h07);
    idle();
    chk("z_ok", frame_ok, 1);
    chk("z_nov", out_valid, 0);
    chk("z_inrdy", in_ready, 1);
    repeat (2) idle();
    chk("z_nowords", mon_q.size(), 0);

    // reset during payload
    o0 = n_ok; e0 = n_err;
    sb(8'hA5); sb(8'h40); sb(8'h04);
    for (int j = 0; j < 6; j++) sb(8'(j + 1));
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("mr_outs", {in_ready, out_valid, out_last, out_data, out_cmd}, 0);
    chk("mr_pulses", {frame_ok, frame_err, err_code}, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("mr_inrdy", in_ready, 1);
    chk("mr_counts", {32'(n_ok - o0), 32'(n_err - e0)}, 0);
    good_frame(8'h66, 4, 8'hA0, "mr_next");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
